// File: rtl/matrix_rc_buf_pkg.sv
// Shared definitions for the matrix_rc_buf slice: loader state codes and index width helper.
package matrix_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  // Width of an index into n entries, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_rc_buf_if.sv
// Bus bundle for matrix_rc_buf: random-access port, stream loader, status and flat view.
// rd_tr exists only when MATRIX_RC_BUF_TRANSPOSE_EN is defined.
interface matrix_rc_buf_if
  import matrix_pkg::*;
#(
  parameter int ROWS = 3,
  parameter int COLS = 3,
  parameter int DW   = 8
) ();
  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);

  logic                    clr;
  logic                    wr_en;
  logic [RW-1:0]           wr_row;
  logic [CW-1:0]           wr_col;
  logic [DW-1:0]           wr_data;
  logic [RW-1:0]           rd_row;
  logic [CW-1:0]           rd_col;
  logic [DW-1:0]           rd_data;
`ifdef MATRIX_RC_BUF_TRANSPOSE_EN
  logic                    rd_tr;
`endif
  logic                    start;
  logic                    s_valid;
  logic [DW-1:0]           s_data;
  logic                    s_ready;
  logic                    load_done;
  logic                    full;
  logic                    addr_err;
  logic [ROWS*COLS*DW-1:0] flat;

  modport master (
`ifdef MATRIX_RC_BUF_TRANSPOSE_EN
    output rd_tr,
`endif
    output clr, wr_en, wr_row, wr_col, wr_data, rd_row, rd_col, start, s_valid, s_data,
    input  rd_data, s_ready, load_done, full, addr_err, flat
  );

  modport slave (
`ifdef MATRIX_RC_BUF_TRANSPOSE_EN
    input  rd_tr,
`endif
    input  clr, wr_en, wr_row, wr_col, wr_data, rd_row, rd_col, start, s_valid, s_data,
    output rd_data, s_ready, load_done, full, addr_err, flat
  );

endinterface

// File: rtl/matrix_rc_buf_loader.sv
// Row-major stream loader FSM for matrix_rc_buf: produces the array write strobe and index.
//   state   | meaning
//   IDLE    | no load in progress, s_ready low
//   LOAD    | accepting beats into element ptr
//   FULL    | last element written, full high until start/clr
module matrix_rc_loader
  import matrix_pkg::*;
#(
  parameter int N  = 9,
  parameter int PW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          start,
  input  logic          wr_en,
  input  logic          s_valid,
  output logic          ld_we,
  output logic [PW-1:0] ld_idx,
  output logic          s_ready,
  output logic          full,
  output logic          load_done
);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          full_q, full_d;
  logic          done_q, done_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    full_d  = full_q;
    done_d  = 1'b0;
    // A random write owns the array port this cycle, so the stream stalls.
    s_ready = (state_q == ST_LOAD) && !wr_en && !clr && !start;
    ld_we   = s_valid && s_ready;
    if (clr) begin
      state_d = ST_IDLE;
      ptr_d   = '0;
      full_d  = 1'b0;
    end else if (start) begin
      state_d = ST_LOAD;
      ptr_d   = '0;
      full_d  = 1'b0;
    end else if (ld_we) begin
      if (ptr_q == PW'(N - 1)) begin
        state_d = ST_FULL;
        ptr_d   = '0;
        full_d  = 1'b1;
        done_d  = 1'b1;
      end else begin
        ptr_d = ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      full_q  <= full_d;
      done_q  <= done_d;
    end
  end

  assign ld_idx    = ptr_q;
  assign full      = full_q;
  assign load_done = done_q;

endmodule

// File: rtl/matrix_rc_buf.sv
// ROWS x COLS element buffer with random-access write/read, row-major stream loader and flat view.
// Define MATRIX_RC_BUF_TRANSPOSE_EN to add rd_tr, which swaps the read row/column.
module matrix_rc_buf
  import matrix_pkg::*;
#(
  parameter int ROWS = 3,
  parameter int COLS = 3,
  parameter int DW   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  matrix_rc_buf_if.slave bus
);

  localparam int          N  = ROWS * COLS;
  localparam int          IW = idx_w(N);
  localparam int unsigned NR = ROWS;
  localparam int unsigned NC = COLS;

  logic [DW-1:0] mem_q [N];
  logic [DW-1:0] mem_d [N];
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          addr_err_q, addr_err_d;

  logic          ld_we;
  logic [IW-1:0] ld_idx;
  logic          wr_ok, rd_ok;
  logic [IW-1:0] wr_idx, rd_idx;
  int unsigned   er, ec;

  matrix_rc_loader #(.N(N)) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (bus.clr),
    .start     (bus.start),
    .wr_en     (bus.wr_en),
    .s_valid   (bus.s_valid),
    .ld_we     (ld_we),
    .ld_idx    (ld_idx),
    .s_ready   (bus.s_ready),
    .full      (bus.full),
    .load_done (bus.load_done)
  );

  always_comb begin
    er = 32'(bus.rd_row);
    ec = 32'(bus.rd_col);
`ifdef MATRIX_RC_BUF_TRANSPOSE_EN
    if (bus.rd_tr) begin
      er = 32'(bus.rd_col);
      ec = 32'(bus.rd_row);
    end
`endif
    wr_ok  = (32'(bus.wr_row) < NR) && (32'(bus.wr_col) < NC);
    rd_ok  = (er < NR) && (ec < NC);
    wr_idx = IW'(32'(bus.wr_row) * NC + 32'(bus.wr_col));
    rd_idx = IW'(er * NC + ec);
  end

  always_comb begin
    for (int i = 0; i < N; i++) mem_d[i] = mem_q[i];
    if (bus.clr) begin
      for (int i = 0; i < N; i++) mem_d[i] = '0;
    end else begin
      if (bus.wr_en && wr_ok) mem_d[wr_idx] = bus.wr_data;
      if (ld_we)              mem_d[ld_idx] = bus.s_data;
    end
    // Reading mem_d gives write-first behaviour for same-cycle writes.
    rd_data_d  = (rd_ok && !bus.clr) ? mem_d[rd_idx] : '0;
    addr_err_d = (bus.wr_en && !wr_ok) || !rd_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
      rd_data_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) mem_q[i] <= mem_d[i];
      rd_data_q  <= rd_data_d;
      addr_err_q <= addr_err_d;
    end
  end

  always_comb begin
    bus.flat = '0;
    for (int i = 0; i < N; i++) bus.flat[(N-1-i)*DW +: DW] = mem_q[i];
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_matrix_rc_buf.sv
// Scoreboard bench for matrix_rc_buf: directed scenarios plus randomized traffic against an array model.
module tb_matrix_rc_buf;

  localparam int ROWS = 3;
  localparam int COLS = 3;
  localparam int DW   = 8;
  localparam int N    = ROWS * COLS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  matrix_rc_buf_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) bus ();
  matrix_rc_buf #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rd;
    logic       err;
    logic       done;
    logic       full;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int   m_arr[N];
  bit   m_loading;
  bit   m_full;
  int   m_ptr;
  bit   tr_v = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [71:0] m_flat();
    logic [71:0] r;
    int v;
    r = '0;
    for (int i = 0; i < N; i++) begin
      v = m_arr[i];
      r[(N-1-i)*8 +: 8] = v[7:0];
    end
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_arr[i] = 0;
    m_loading = 0;
    m_full    = 0;
    m_ptr     = 0;
  endtask

  // One clock of stimulus; the model predicts the registered outputs after the edge.
  task automatic step(input bit clr, input bit st, input bit we, input int wr, input int wc,
                      input int wd, input bit sv, input int sd, input int rr, input int rc);
    exp_t e;
    bit   rdy, wok, rok, done;
    int   er, ec, v;
    @(negedge clk);
    bus.clr     = clr;
    bus.start   = st;
    bus.wr_en   = we;
    bus.wr_row  = wr[1:0];
    bus.wr_col  = wc[1:0];
    bus.wr_data = wd[7:0];
    bus.s_valid = sv;
    bus.s_data  = sd[7:0];
    bus.rd_row  = rr[1:0];
    bus.rd_col  = rc[1:0];
`ifdef MATRIX_RC_BUF_TRANSPOSE_EN
    bus.rd_tr   = tr_v;
`endif
    #1;
    rdy = m_loading && !we && !clr && !st;
    chk("s_ready", bus.s_ready, rdy);
    er = rr; ec = rc;
`ifdef MATRIX_RC_BUF_TRANSPOSE_EN
    if (tr_v) begin er = rc; ec = rr; end
`endif
    wok  = (wr < ROWS) && (wc < COLS);
    rok  = (er < ROWS) && (ec < COLS);
    done = 0;
    if (clr) begin
      m_reset();
    end else begin
      if (st) begin
        m_loading = 1; m_full = 0; m_ptr = 0;
      end
      if (we && wok) m_arr[wr*COLS+wc] = wd & 8'hFF;
      if (sv && rdy) begin
        m_arr[m_ptr] = sd & 8'hFF;
        if (m_ptr == N-1) begin
          m_loading = 0; m_full = 1; m_ptr = 0; done = 1;
        end else m_ptr++;
      end
    end
    v      = (rok && !clr) ? m_arr[er*COLS+ec] : 0;
    e.rd   = v[7:0];
    e.err  = (we && !wok) || !rok;
    e.done = done;
    e.full = m_full;
    sb.push_back(e);
  endtask

  task automatic beat(input int d);
    step(0, 0, 0, 0, 0, 0, 1, d, 0, 0);
  endtask

  task automatic do_start();
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_flat(input string nm);
    @(posedge clk); #2;
    chk(nm, bus.flat, m_flat());
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rd_data", bus.rd_data, e.rd);
        chk("addr_err", bus.addr_err, e.err);
        chk("load_done", bus.load_done, e.done);
        chk("full", bus.full, e.full);
      end
    end
  end

  initial begin : stim
    bus.clr = 0; bus.start = 0; bus.wr_en = 0; bus.wr_row = 0; bus.wr_col = 0;
    bus.wr_data = 0; bus.s_valid = 0; bus.s_data = 0; bus.rd_row = 0; bus.rd_col = 0;
`ifdef MATRIX_RC_BUF_TRANSPOSE_EN
    bus.rd_tr = 0;
`endif
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_load_done", bus.load_done, 0);
    chk("rst_addr_err", bus.addr_err, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_flat", bus.flat, 0);
    @(negedge clk);
    rst_n = 1;

    // Full sequential load 1..9
    do_start();
    for (int i = 1; i <= 9; i++) beat(i);
    @(posedge clk); #2;
    chk("flat_seq", bus.flat, 72'h010203040506070809);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Write-first read and out-of-range read
    step(0, 0, 1, 1, 2, 'hAA, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
    step(0, 0, 1, 3, 1, 'h77, 0, 0, 0, 0);
    chk_flat("flat_after_wr");

    // Random write stalls the stream at ptr=4
    do_start();
    for (int i = 1; i <= 4; i++) beat(i);
    step(0, 0, 1, 0, 0, 'h55, 1, 5, 0, 0);
    beat(5);
    @(posedge clk); #2;
    chk("stall_wr00", bus.flat[71:64], 8'h55);
    chk("stall_idx4", bus.flat[39:32], 8'h05);
    for (int i = 6; i <= 9; i++) beat(i);
    chk_flat("flat_stall_load");

    // clr mid-load, then reload
    do_start();
    for (int i = 1; i <= 6; i++) beat(i);
    step(1, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    @(posedge clk); #2;
    chk("clr_flat", bus.flat, 0);
    step(0, 0, 0, 0, 0, 0, 1, 7, 2, 2);
    do_start();
    for (int i = 16; i <= 24; i++) beat(i);
    chk_flat("flat_reload");

    // Async reset mid-load
    do_start();
    for (int i = 1; i <= 3; i++) beat(i);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("arst_rd_data", bus.rd_data, 0);
    chk("arst_full", bus.full, 0);
    chk("arst_load_done", bus.load_done, 0);
    chk("arst_addr_err", bus.addr_err, 0);
    chk("arst_s_ready", bus.s_ready, 0);
    chk("arst_flat", bus.flat, 0);
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) beat(i + 40);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
`ifdef MATRIX_RC_BUF_TRANSPOSE_EN
      tr_v = 1'($urandom_range(0, 1));
`endif
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 25,
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255),
           $urandom_range(0, 99) < 75, $urandom_range(0, 255),
           $urandom_range(0, 3), $urandom_range(0, 3));
      if (k % 100 == 99) chk_flat("flat_rand");
    end

    repeat (3) @(posedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
